// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: PC, single-outstanding imem handshake,
// instruction holding register and immediate-format select for decode.
module fetch_unit #(
  parameter int unsigned WIDTH    = 20,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [WIDTH+11:0]   imem_rdata,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [WIDTH+11:0]   inst_data,
  output logic [31:0]         inst_pc,
  output logic [1:0]          imm_en
);

  localparam int unsigned IW = WIDTH + 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP,
    S_HOLD
  } state_t;

  state_t          state, state_d;
  logic [31:0]     pc, pc_d;
  logic            inst_valid_d;
  logic [IW-1:0]   inst_data_d;
  logic [31:0]     inst_pc_d;
  logic [1:0]      imm_en_d;

  // Immediate format from the 7-bit opcode
  function automatic logic [1:0] imm_decode(input logic [6:0] op);
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111: return 2'b01;
      7'b1100011:                         return 2'b10;
      7'b0110111, 7'b0010111:             return 2'b11;
      default:                            return 2'b00;
    endcase
  endfunction

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
      inst_data  <= '0;
      inst_pc    <= 32'h0;
      imm_en     <= 2'b00;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      inst_valid <= inst_valid_d;
      inst_data  <= inst_data_d;
      inst_pc    <= inst_pc_d;
      imm_en     <= imm_en_d;
    end
  end

  // Next state; a redirect overrides the PC in every state and squashes
  // whatever instruction or fetch is currently in progress.
  always_comb begin
    state_d      = state;
    pc_d         = pc;
    inst_valid_d = inst_valid;
    inst_data_d  = inst_data;
    inst_pc_d    = inst_pc;
    imm_en_d     = imm_en;

    case (state)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_gnt) state_d = redirect_valid ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid) begin
          state_d = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          inst_data_d  = imem_rdata;
          inst_pc_d    = pc;
          imm_en_d     = imm_decode(imem_rdata[6:0]);
          inst_valid_d = 1'b1;
          pc_d         = pc + 32'd4;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid || inst_ready) begin
          inst_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) pc_d = {redirect_pc[31:2], 2'b00};
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected instructions into a
// scoreboard, a monitor pops and compares each time inst_valid rises.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst2 = 1'b1;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic        ready = 1'b0;
  logic        sel = 1'b0;

  logic        req1, req2, v1, v2;
  logic [31:0] addr1, addr2, data1, data2, ipc1, ipc2;
  logic [1:0]  imm1, imm2;

  logic        m_rst, m_req, m_valid;
  logic [31:0] m_addr, m_data, m_pc;
  logic [1:0]  m_imm;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic [1:0]  imm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic prev_v = 1'b0;

  always #5 clk = ~clk;

  fetch_unit dut1 (
    .clk(clk), .rst(rst), .imem_req(req1), .imem_addr(addr1), .imem_gnt(gnt),
    .imem_rvalid(rvalid), .imem_rdata(rdata), .redirect_valid(redir),
    .redirect_pc(redir_pc), .inst_valid(v1), .inst_ready(ready),
    .inst_data(data1), .inst_pc(ipc1), .imm_en(imm1)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst2), .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt),
    .imem_rvalid(rvalid), .imem_rdata(rdata), .redirect_valid(redir),
    .redirect_pc(redir_pc), .inst_valid(v2), .inst_ready(ready),
    .inst_data(data2), .inst_pc(ipc2), .imm_en(imm2)
  );

  assign m_rst   = sel ? rst2  : rst;
  assign m_req   = sel ? req2  : req1;
  assign m_addr  = sel ? addr2 : addr1;
  assign m_valid = sel ? v2    : v1;
  assign m_data  = sel ? data2 : data1;
  assign m_pc    = sel ? ipc2  : ipc1;
  assign m_imm   = sel ? imm2  : imm1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Monitor: each new instruction presented must match the oldest expectation
  always @(negedge clk) begin
    if (m_rst) begin
      prev_v = 1'b0;
    end else begin
      if (m_valid && !prev_v) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_inst: got data=%h pc=%h, required no instruction", m_data, m_pc);
        end else begin
          mon_e = sb.pop_front();
          check("inst_data", m_data, mon_e.data);
          check("inst_pc", m_pc, mon_e.pc);
          check("imm_en", 32'(m_imm), 32'(mon_e.imm));
        end
      end
      prev_v = m_valid;
    end
  end

  task automatic wait_req();
    int k = 0;
    while (!m_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!m_req) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_timeout: got imem_req=0, required 1 within 20 cycles");
    end
  endtask

  // One fetch: optional grant stall, grant, optional response delay, response.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                          input int gnt_dly, input int rv_dly);
    wait_req();
    for (int i = 0; i < gnt_dly; i++) begin
      check("stall_req", 32'(m_req), 32'd1);
      check("stall_addr", m_addr, addr);
      @(negedge clk);
    end
    check("req_addr", m_addr, addr);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    repeat (rv_dly) @(negedge clk);
    rvalid = 1'b1;
    rdata  = data;
    @(negedge clk);
    rvalid = 1'b0;
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic [31:0] p, input logic [1:0] i);
    exp_t e;
    e.data = d;
    e.pc   = p;
    e.imm  = i;
    return e;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_req", 32'(m_req), 32'd0);
    check("rst_addr", m_addr, 32'h0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", m_data, 32'h0);
    check("rst_pc", m_pc, 32'h0);
    check("rst_imm", 32'(m_imm), 32'd0);

    rst = 1'b0;
    #1 check("idle_req", 32'(m_req), 32'd0);
    @(negedge clk);
    check("first_req", 32'(m_req), 32'd1);

    // First fetch, then back-pressure in HOLD
    sb.push_back(mk(32'h0050_0093, 32'h0, 2'b01));
    do_fetch(32'h0, 32'h0050_0093, 0, 0);
    check("zw_valid", 32'(m_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", 32'(m_valid), 32'd1);
      check("bp_req", 32'(m_req), 32'd0);
      check("bp_data", m_data, 32'h0050_0093);
    end
    ready = 1'b1;
    @(negedge clk);
    check("rel_req", 32'(m_req), 32'd1);
    check("rel_addr", m_addr, 32'h4);

    // Immediate formats, with grant stalls and response delays
    sb.push_back(mk(32'hFE00_0EE3, 32'h4, 2'b10));
    do_fetch(32'h4, 32'hFE00_0EE3, 2, 1);
    sb.push_back(mk(32'h1234_5037, 32'h8, 2'b11));
    do_fetch(32'h8, 32'h1234_5037, 0, 0);
    sb.push_back(mk(32'h00B5_0533, 32'hC, 2'b00));
    do_fetch(32'hC, 32'h00B5_0533, 0, 2);

    // Redirect while waiting; late response must be dropped
    wait_req();
    check("w_addr", m_addr, 32'h10);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0; redir = 1'b1; redir_pc = 32'h100;
    @(negedge clk);
    redir = 1'b0;
    check("drop_valid", 32'(m_valid), 32'd0);
    check("drop_req", 32'(m_req), 32'd0);
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rvalid = 1'b0;
    check("post_drop_valid", 32'(m_valid), 32'd0);
    check("post_drop_addr", m_addr, 32'h100);
    sb.push_back(mk(32'h0000_2003, 32'h100, 2'b01));
    do_fetch(32'h100, 32'h0000_2003, 0, 0);

    // Redirect in REQ with grant, then redirect in REQ without grant
    wait_req();
    check("rg_addr", m_addr, 32'h104);
    gnt = 1'b1; redir = 1'b1; redir_pc = 32'h300;
    @(negedge clk);
    gnt = 1'b0; redir = 1'b0;
    check("rg_req", 32'(m_req), 32'd0);
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'h1234_5037;
    @(negedge clk);
    rvalid = 1'b0;
    check("rg_addr2", m_addr, 32'h300);
    redir = 1'b1; redir_pc = 32'h400;
    @(negedge clk);
    redir = 1'b0;
    check("rn_req", 32'(m_req), 32'd1);
    check("rn_addr", m_addr, 32'h400);

    // Redirect in HOLD together with inst_ready squashes the instruction
    ready = 1'b0;
    sb.push_back(mk(32'h00C0_006F, 32'h400, 2'b00));
    do_fetch(32'h400, 32'h00C0_006F, 0, 0);
    redir = 1'b1; redir_pc = 32'h200; ready = 1'b1;
    @(negedge clk);
    redir = 1'b0; ready = 1'b0;
    check("hold_sq_valid", 32'(m_valid), 32'd0);
    check("hold_sq_addr", m_addr, 32'h200);
    sb.push_back(mk(32'h0000_8067, 32'h200, 2'b01));
    do_fetch(32'h200, 32'h0000_8067, 0, 0);
    redir = 1'b1; redir_pc = 32'h103;
    @(negedge clk);
    redir = 1'b0;
    check("align_valid", 32'(m_valid), 32'd0);
    check("align_addr", m_addr, 32'h100);
    sb.push_back(mk(32'h0040_0113, 32'h100, 2'b01));
    do_fetch(32'h100, 32'h0040_0113, 0, 0);

    // Redirect coinciding with the response in WAIT
    ready = 1'b1;
    wait_req();
    check("wr_addr", m_addr, 32'h104);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0; rvalid = 1'b1; rdata = 32'h0BAD_C0DE; redir = 1'b1; redir_pc = 32'h500;
    @(negedge clk);
    rvalid = 1'b0; redir = 1'b0;
    check("wr_valid", 32'(m_valid), 32'd0);
    check("wr_addr2", m_addr, 32'h500);

    // PC wrap and mid-fetch reset on the second instance
    rst = 1'b1;
    sel = 1'b1;
    #1;
    check("r2_addr", m_addr, 32'hFFFF_FFFC);
    check("r2_req", 32'(m_req), 32'd0);
    @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    sb.push_back(mk(32'h0000_0537, 32'hFFFF_FFFC, 2'b11));
    do_fetch(32'hFFFF_FFFC, 32'h0000_0537, 0, 0);
    wait_req();
    check("wrap_addr", m_addr, 32'h0);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    rst2 = 1'b1;
    #1;
    check("mr_req", 32'(m_req), 32'd0);
    check("mr_addr", m_addr, 32'hFFFF_FFFC);
    check("mr_valid", 32'(m_valid), 32'd0);
    check("mr_data", m_data, 32'h0);
    check("mr_pc", m_pc, 32'h0);
    check("mr_imm", 32'(m_imm), 32'd0);
    @(negedge clk);
    rst2 = 1'b0; rvalid = 1'b1; rdata = 32'h0050_0093;
    @(negedge clk);
    rvalid = 1'b0;
    check("stale_valid", 32'(m_valid), 32'd0);
    check("stale_req", 32'(m_req), 32'd1);
    check("stale_addr", m_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I core. Issues word fetches to instruction memory over a request/grant/response handshake, keeps the PC, and holds each returned instruction in a register for the decode/immediate stage. Alongside each instruction it produces the immediate-format select `imm_en` consumed by the immediate unit. Supports PC redirect from branch/jump resolution, including discard of an in-flight fetch.

## Interface
- `WIDTH`, default 20: instruction width is `WIDTH+12`, which is 32 bits at the default.
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request; equals (state==REQ).
- `imem_addr`  out  32  fetch address; equals `pc`.
- `imem_gnt`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response data valid; one response per grant.
- `imem_rdata`  in  WIDTH+12  response instruction word.
- `redirect_valid`  in  1  load a new PC (branch/jump taken).
- `redirect_pc`  in  32  target PC; the block uses bits [31:2], and bits [1:0] are forced to 0.
- `inst_valid`  out  1  `inst_data`/`inst_pc`/`imm_en` hold a valid instruction.
- `inst_ready`  in  1  downstream accepts the instruction.
- `inst_data`  out  WIDTH+12  registered instruction word.
- `inst_pc`  out  32  PC of `inst_data`.
- `imm_en`  out  2  immediate format: 01 I-type, 10 B-type, 11 U-type, 00 none.

## Operation
- States: IDLE, REQ, WAIT, DROP, HOLD. Reset state is IDLE.
- IDLE → REQ unconditionally on the next clock.
- REQ:
  - `imem_req`=1.
  - If `imem_gnt`: go to WAIT.
  - Otherwise stay in REQ, with `imem_addr` held stable.
- WAIT:
  - On `imem_rvalid`: capture `inst_data`←`imem_rdata`, `inst_pc`←`pc`, `imm_en`←decode(`imem_rdata[6:0]`).
  - Same edge: `pc`←`pc`+4 (modulo 2^32, wraps from 0xFFFF_FFFC to 0), `inst_valid`←1, go to HOLD.
- HOLD:
  - `inst_valid`=1, and all `inst_*` and `imm_en` outputs hold stable.
  - On `inst_ready`: `inst_valid`←0, go to REQ.
- DROP: wait for `imem_rvalid`, discard the data (no `inst_*` update), then go to REQ.
- Redirect has highest priority. When `redirect_valid`=1:
  - `pc`←{`redirect_pc[31:2]`,2'b00} in every state.
  - REQ with no `imem_gnt`: stay in REQ. The new address appears next cycle.
  - REQ with `imem_gnt` in the same cycle: go to DROP, because the old-PC fetch was accepted.
  - WAIT with no `imem_rvalid`: go to DROP.
  - WAIT with `imem_rvalid` in the same cycle: discard the data and go to REQ. `inst_valid` stays 0.
  - HOLD: `inst_valid`←0 and go to REQ, even if `inst_ready` is also high. The instruction is squashed.
  - IDLE/DROP: state transitions are unchanged; only `pc` is updated.
- `imm_en` decode:
  - 01 for opcodes 0010011, 0000011, 1100111.
  - 10 for 1100011.
  - 11 for 0110111, 0010111.
  - 00 for all other opcodes.
- At most one outstanding memory request. `imem_rvalid` outside WAIT/DROP is ignored.

## Timing
- Reset values: `pc`=RESET_PC, `imem_req`=0, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `imm_en`=2'b00.
- Reset mid-operation aborts immediately. Any in-flight response arriving after reset release is ignored, because the FSM is not in WAIT/DROP.
- After reset deasserts: IDLE for 1 cycle, `imem_req` high from cycle 2.
- With zero-wait memory (gnt in the REQ cycle, rvalid the following cycle), `inst_valid` rises 1 cycle after rvalid.
- Steady-state throughput with `inst_ready` held high: one instruction per 3 cycles (REQ, WAIT, HOLD).
- `imem_req` and `imem_addr` are combinational from registered state and `pc` only. There is no combinational path from any input to any output.

## Test plan
- Reset release, memory grants immediately and returns 0x00500093 (addi) one cycle later → `imem_addr`=0x0, `inst_valid`=1 with `inst_data`=0x00500093, `inst_pc`=0x0, `imm_en`=01. The next request is at 0x4.
- Back-pressure: `inst_ready`=0 for 5 cycles in HOLD → outputs stable and `imem_req`=0 throughout. On `inst_ready`=1, `imem_req`=1 the next cycle with addr 0x4.
- Formats: return 0xFE000EE3 (beq), 0x12345037 (lui), 0x00B50533 (add) → `imm_en` = 10, 11, 00 respectively.
- Redirect in WAIT to 0x100, with rvalid 3 cycles later carrying 0xDEADBEEF → data discarded, `inst_valid` stays 0, and the next request is addr 0x100.
- Redirect in HOLD coinciding with `inst_ready` → `inst_valid` drops to 0, and the next fetch is the redirect target. Also redirect with `redirect_pc`=0x103 → fetch addr 0x100.
- Wrap: RESET_PC=0xFFFF_FFFC, one fetch completed → next `imem_addr`=0x0. Assert `rst` while in WAIT → all outputs return to reset values immediately.
